// File: rtl/inst_buffer.sv
// inst_buffer: dual-slot instruction queue between fetch and decode.
// Fetch pushes up to two entries per cycle; decode sees the oldest two
// show-ahead and pops zero, one or two of them. A redirect flush empties it.
module inst_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [1:0][31:0] in_pc,
  input  logic [1:0][31:0] in_inst,
  input  logic [1:0]       in_pred_taken,
  input  logic [1:0][31:0] in_pred_target,
  input  logic [1:0]       in_adef,
  output logic             in_ready,
  output logic [1:0]       out_valid,
  output logic [1:0][31:0] out_pc,
  output logic [1:0][31:0] out_inst,
  output logic [1:0]       out_pred_taken,
  output logic [1:0][31:0] out_pred_target,
  output logic [1:0]       out_adef,
  input  logic [1:0]       pop
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        adef;
  } entry_t;

  localparam logic [PTR_W:0] CNT_ONE       = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO       = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] CNT_READY_MAX = (PTR_W+1)'(DEPTH - 2);

  entry_t           mem [DEPTH];
  entry_t           wr_entry [2];
  entry_t           rd_entry [2];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;

  logic             push_en;
  logic [1:0]       push_cnt;
  logic [1:0]       pop_cnt;

  // Ready only looks at the registered count, so it never depends on a same-cycle pop.
  assign in_ready  = (count <= CNT_READY_MAX);
  assign out_valid = {(count >= CNT_TWO), (count >= CNT_ONE)};

  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  // Gather the two incoming slots into entries for storage.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wr_entry[i].pc          = in_pc[i];
      wr_entry[i].inst        = in_inst[i];
      wr_entry[i].pred_taken  = in_pred_taken[i];
      wr_entry[i].pred_target = in_pred_target[i];
      wr_entry[i].adef        = in_adef[i];
    end
  end

  // Work out how many entries go in and come out this cycle; pop=10 counts as no pop.
  always_comb begin
    push_en  = in_ready && in_valid[0] && !flush;
    push_cnt = 2'd0;
    if (push_en) begin
      push_cnt = in_valid[1] ? 2'd2 : 2'd1;
    end
    pop_cnt = 2'd0;
    if (pop[0] && out_valid[0]) begin
      pop_cnt = 2'd1;
      if (pop[1] && out_valid[1]) begin
        pop_cnt = 2'd2;
      end
    end
    count_next = count + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop_cnt);
  end

  // Entry storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[tail] <= wr_entry[0];
      if (in_valid[1]) begin
        mem[tail_p1] <= wr_entry[1];
      end
    end
  end

  // Head, tail and count; flush outranks any same-cycle push or pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_cnt);
      count <= count_next;
    end
  end

  // Show-ahead read of the two oldest entries; pointers wrap naturally.
  always_comb begin
    rd_entry[0] = mem[head];
    rd_entry[1] = mem[head_p1];
  end

  // Split the head entries back out onto the decoder-facing ports.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      out_pc[i]          = rd_entry[i].pc;
      out_inst[i]        = rd_entry[i].inst;
      out_pred_taken[i]  = rd_entry[i].pred_taken;
      out_pred_target[i] = rd_entry[i].pred_target;
      out_adef[i]        = rd_entry[i].adef;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: scoreboard bench for inst_buffer. Stimulus queues the entries
// it expects the buffer to accept; a negedge monitor compares the head slots.
module tb_inst_buffer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        adef;
  } entry_t;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0][31:0] in_inst;
  logic [1:0]       in_pred_taken;
  logic [1:0][31:0] in_pred_target;
  logic [1:0]       in_adef;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_inst;
  logic [1:0]       out_pred_taken;
  logic [1:0][31:0] out_pred_target;
  logic [1:0]       out_adef;
  logic [1:0]       pop;

  entry_t exp_q[$];
  entry_t push_q[$];
  int     total = 0;
  int     bad   = 0;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .in_valid(in_valid),
    .in_pc(in_pc),
    .in_inst(in_inst),
    .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target),
    .in_adef(in_adef),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .out_pred_taken(out_pred_taken),
    .out_pred_target(out_pred_target),
    .out_adef(out_adef),
    .pop(pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic entry_t rand_entry();
    entry_t e;
    e.pc          = {$urandom} & 32'hffff_fffc;
    e.inst        = $urandom;
    e.pred_taken  = 1'($urandom_range(0, 1));
    e.pred_target = $urandom;
    e.adef        = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic entry_t dut_slot(input int i);
    entry_t e;
    e.pc          = out_pc[i];
    e.inst        = out_inst[i];
    e.pred_taken  = out_pred_taken[i];
    e.pred_target = out_pred_target[i];
    e.adef        = out_adef[i];
    return e;
  endfunction

  // Drive one cycle of inputs and queue whatever the reference says gets accepted.
  task automatic apply_stimulus(input logic [1:0] v, input logic [1:0] p, input logic f,
                                input entry_t e0, input entry_t e1);
    @(posedge clk);
    #1;
    in_valid          = v;
    pop               = p;
    flush             = f;
    in_pc[0]          = e0.pc;
    in_inst[0]        = e0.inst;
    in_pred_taken[0]  = e0.pred_taken;
    in_pred_target[0] = e0.pred_target;
    in_adef[0]        = e0.adef;
    in_pc[1]          = e1.pc;
    in_inst[1]        = e1.inst;
    in_pred_taken[1]  = e1.pred_taken;
    in_pred_target[1] = e1.pred_target;
    in_adef[1]        = e1.adef;
    if (!f && v[0] && (DEPTH - exp_q.size()) >= 2) begin
      push_q.push_back(e0);
      if (v[1]) push_q.push_back(e1);
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(2'b00, 2'b00, 1'b0, '0, '0);
  endtask

  task automatic push_two();
    apply_stimulus(2'b11, 2'b00, 1'b0, rand_entry(), rand_entry());
  endtask

  // Reference: the queue itself is the buffer; compare visible slots, then advance it.
  always @(negedge clk) begin
    int n;
    int k;
    n = exp_q.size();
    check_output("in_ready", 128'(in_ready), 128'((DEPTH - n) >= 2));
    check_output("out_valid", 128'(out_valid), 128'({n >= 2, n >= 1}));
    if (n >= 1) check_output("slot0", 128'(dut_slot(0)), 128'(exp_q[0]));
    if (n >= 2) check_output("slot1", 128'(dut_slot(1)), 128'(exp_q[1]));
    if (!resetn || flush) begin
      exp_q.delete();
    end else begin
      if (pop == 2'b10) $display("[TB] note: illegal pop=10 seen, treated as no pop");
      k = (pop == 2'b11) ? 2 : (pop == 2'b01) ? 1 : 0;
      if (k > n) k = n;
      for (int i = 0; i < k; i++) void'(exp_q.pop_front());
      while (push_q.size() > 0) exp_q.push_back(push_q.pop_front());
    end
    push_q.delete();
  end

  initial begin
    entry_t a;
    entry_t b;
    logic [1:0] v;
    logic [1:0] p;
    resetn = 1'b0;
    flush = 1'b0;
    in_valid = 2'b00;
    pop = 2'b00;
    in_pc = '0;
    in_inst = '0;
    in_pred_taken = '0;
    in_pred_target = '0;
    in_adef = '0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;

    $display("[TB] first push after reset");
    a = rand_entry(); a.pc = 32'h1c00_0000;
    b = rand_entry(); b.pc = 32'h1c00_0004;
    apply_stimulus(2'b11, 2'b00, 1'b0, a, b);

    $display("[TB] fill to full, then an ignored push");
    for (int i = 0; i < 7; i++) push_two();
    push_two();

    $display("[TB] almost-full blocking and push+pop together");
    apply_stimulus(2'b00, 2'b01, 1'b0, '0, '0);
    push_two();
    apply_stimulus(2'b00, 2'b01, 1'b0, '0, '0);
    apply_stimulus(2'b11, 2'b11, 1'b0, rand_entry(), rand_entry());
    run_idle(1);

    $display("[TB] pointer wrap with a split pair");
    apply_stimulus(2'b00, 2'b00, 1'b1, '0, '0);
    for (int i = 0; i < 15; i++) apply_stimulus(2'b01, 2'b01, 1'b0, rand_entry(), '0);
    apply_stimulus(2'b00, 2'b01, 1'b0, '0, '0);
    a = rand_entry(); b = rand_entry();
    apply_stimulus(2'b11, 2'b00, 1'b0, a, b);
    run_idle(1);
    apply_stimulus(2'b00, 2'b11, 1'b0, '0, '0);
    run_idle(1);

    $display("[TB] flush beats push and pop");
    for (int i = 0; i < 3; i++) push_two();
    apply_stimulus(2'b11, 2'b11, 1'b1, rand_entry(), rand_entry());
    run_idle(2);

    $display("[TB] flag bits, illegal pop, async reset");
    a = rand_entry(); a.adef = 1'b1; a.pred_taken = 1'b0;
    b = rand_entry(); b.adef = 1'b0; b.pred_taken = 1'b1; b.pred_target = 32'h1c00_0100;
    apply_stimulus(2'b11, 2'b00, 1'b0, a, b);
    run_idle(1);
    apply_stimulus(2'b00, 2'b10, 1'b0, '0, '0);
    run_idle(1);
    push_two();
    @(posedge clk);
    #3;
    resetn = 1'b0;
    in_valid = 2'b00;
    pop = 2'b00;
    #1;
    check_output("async_reset_out_valid", 128'(out_valid), 128'(2'b00));
    check_output("async_reset_in_ready", 128'(in_ready), 128'(1'b1));
    exp_q.delete();
    push_q.delete();
    @(posedge clk);
    #2 resetn = 1'b1;

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2: p = 2'b00;
        3, 4, 5: p = 2'b01;
        6, 7, 8: p = 2'b11;
        default: p = 2'b10;
      endcase
      apply_stimulus(v, p, ($urandom_range(0, 29) == 0), rand_entry(), rand_entry());
    end
    run_idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-slot instruction queue between fetch (IF) and the decode stage.
- Decouples the fetch-side accept rate from the decode-side consume rate.
- Accepts up to 2 fetched instructions per cycle, each with its PC, branch prediction and fetch-exception flag.
- Presents the oldest 2 entries show-ahead to the two decoders, which pop 0–2 per cycle.
- Flushed on any redirect: branch mispredict, exception or ertn.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and ≥ 4.
- PTR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  discard all entries; highest priority.
- in_valid  input  2  per-slot push valid; slot1 is valid only if slot0 is valid.
- in_pc  input  2x32  fetch PCs (slot0 older).
- in_inst  input  2x32  instruction words.
- in_pred_taken  input  2  predicted-taken bits.
- in_pred_target  input  2x32  predicted targets.
- in_adef  input  2  fetch address-error flags.
- in_ready  output  1  buffer can take 2 entries this cycle.
- out_valid  output  2  entries visible at head (slot0) and head+1 (slot1).
- out_pc  output  2x32  head PCs.
- out_inst  output  2x32  head instruction words.
- out_pred_taken  output  2  head predicted-taken bits.
- out_pred_target  output  2x32  head predicted targets.
- out_adef  output  2  head fetch-exception flags.
- pop  input  2  decode consumed: 2'b00 none, 2'b01 slot0 only, 2'b11 both; 2'b10 is illegal.

Behaviour:
- Storage:
  - DEPTH entries of {pc, inst, pred_taken, pred_target, adef} = 98 bits.
  - Registers head, tail (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset (resetn low, asynchronous): head=0, tail=0, count=0, so out_valid=2'b00 and in_ready=1 immediately. Entry storage is not reset.
- in_ready:
  - Combinational from the count register only: in_ready = (DEPTH − count) ≥ 2.
  - Never depends on same-cycle pop.
- Push:
  - A push occurs when in_ready && in_valid[0].
  - Slot0 is written at tail.
  - Slot1, if in_valid[1], is written at tail+1 (wrapping).
  - tail advances by popcount(in_valid). Written data is visible at the outputs the next cycle.
  - in_valid with in_ready=0 is ignored; fetch must hold its data.
- Outputs (show-ahead, combinational from storage):
  - out_valid[0] = count ≥ 1; out_valid[1] = count ≥ 2.
  - Slot0 reads head; slot1 reads head+1 (wrapping).
  - Data on invalid slots is don't-care.
- Pop:
  - head advances by popcount(pop & out_valid); a pop of a non-valid slot is ignored.
  - pop=2'b10 is treated as 2'b00, and the bench flags it.
- Simultaneous push and pop in one cycle: count_next = count + pushed − popped. A full-to-free transition lets in_ready rise next cycle.
- Flush:
  - flush=1: head, tail and count reset to 0 next cycle.
  - Same-cycle push and pop are discarded.
  - out_valid is 0 the cycle after a flush.
- Boundaries:
  - count == DEPTH−1: in_ready=0, even for a single-slot push.
  - Pointer wrap from DEPTH−1 to 0 is seamless for both reads and writes.
  - An entry split across the wrap (slot0 at DEPTH−1, slot1 at 0) is handled correctly.
  - Reset asserted mid-operation empties the buffer regardless of flush, push or pop.
- Latency: push to visible at out slot0 is 1 cycle when the buffer was empty. There is no combinational path from in_* to out_*.

Test Plan:
- Reset then push {pc=0x1c000000, 0x1c000004} with in_valid=11 → next cycle out_valid=11, out_pc={0x1c000000, 0x1c000004}, in_ready=1.
- Push 2 per cycle with pop=00 for 7 cycles (count=14) → in_ready=1. After the 8th push, count=16 and in_ready=0; a further push with in_valid=11 is ignored and out_pc[0] is unchanged.
- Buffer at count=15: push blocked (in_ready=0). Pop=01 → count=14, in_ready=1 next cycle. Then push 2 with pop 2 in the same cycle → count stays 14.
- Wrap: advance head and tail to 15, push {A, B} → slot0 from entry 15 and slot1 from entry 0. Out order is A, B; pop=11 leaves count=0.
- Flush with in_valid=11 and pop=11 in the same cycle (count=6) → next cycle count=0, out_valid=00, in_ready=1; the pushed data never appears.
- Push with in_adef={0,1}, pred_taken={1,0}, pred_target={0x1c000100, x} → outputs reproduce the flags bit-exact. Pop=10 changes nothing. Asserting resetn=0 mid-stream empties the buffer asynchronously.
